hex_display_scan: RTL

- Multiplexed 4-digit seven-segment scan driver.
- Consumes the 16-bit result word produced by the I2C master and shows it as four hex digits on the board display.
- Runs on the board system clock, not on the divided I2C clock.
- Captures the word on a load strobe, so the display never shows a half-updated value.

---
 rtl/hex_display_scan_if.sv | 21 ++
 rtl/hex_display_scan.sv | 112 +++++++++++
 2 files changed

// File: rtl/hex_display_scan_if.sv
// Display bus: word/strobe/options from the producer, segment/anode drive to the board.
// master = producer side, slave = scan driver side.
interface hex_display_scan_if;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  dp_en;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    modport master (
        output value, load, blank_lz, dp_en,
        input  seg, dp, an
    );

    modport slave (
        input  value, load, blank_lz, dp_en,
        output seg, dp, an
    );
endinterface

// File: rtl/hex_display_scan.sv
// Multiplexed 4-digit hex seven-segment scan driver with shadowed value and leading-zero blanking.
// Latency: outputs registered, one cycle behind the refresh counter/digit index.
// Backpressure: none; load is a strobe and is always accepted.
module hex_display_scan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic             clk,
    input  logic             reset,
    hex_display_scan_if.slave bus
);
    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    logic [15:0]   r_shadow;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;

    logic          w_blank;
    logic          w_sup;
    logic [3:0]    w_nib;
    logic [6:0]    w_seg_dec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shadow <= 16'h0000;
            r_cnt    <= '0;
            r_idx    <= 2'd0;
        end else begin
            if (bus.load) begin
                r_shadow <= bus.value;
            end
            if (r_cnt == CNT_MAX) begin
                r_cnt <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // A zero-length blank window must not produce an always-false compare against 0.
    generate
        if (BLANK_CYCLES > 0) begin : g_blank
            localparam logic [CW-1:0] BLANK_W = CW'(BLANK_CYCLES);
            assign w_blank = (r_cnt < BLANK_W);
        end else begin : g_no_blank
            assign w_blank = 1'b0;
        end
    endgenerate

    assign w_nib = r_shadow[{r_idx, 2'b00} +: 4];

    // Digit k>=1 is a leading zero when it and every higher nibble are zero.
    always_comb begin
        w_sup = 1'b0;
        if (bus.blank_lz) begin
            case (r_idx)
                2'd1:    w_sup = (r_shadow[15:4]  == 12'h000);
                2'd2:    w_sup = (r_shadow[15:8]  == 8'h00);
                2'd3:    w_sup = (r_shadow[15:12] == 4'h0);
                default: w_sup = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_seg_dec = 7'h7F;
        case (w_nib)
            4'h0: w_seg_dec = 7'h40;
            4'h1: w_seg_dec = 7'h79;
            4'h2: w_seg_dec = 7'h24;
            4'h3: w_seg_dec = 7'h30;
            4'h4: w_seg_dec = 7'h19;
            4'h5: w_seg_dec = 7'h12;
            4'h6: w_seg_dec = 7'h02;
            4'h7: w_seg_dec = 7'h78;
            4'h8: w_seg_dec = 7'h00;
            4'h9: w_seg_dec = 7'h10;
            4'hA: w_seg_dec = 7'h08;
            4'hB: w_seg_dec = 7'h03;
            4'hC: w_seg_dec = 7'h46;
            4'hD: w_seg_dec = 7'h21;
            4'hE: w_seg_dec = 7'h06;
            4'hF: w_seg_dec = 7'h0E;
            default: w_seg_dec = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
            r_an  <= 4'hF;
        end else if (w_blank || w_sup) begin
            r_seg <= 7'h7F;
            r_dp  <= 1'b1;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_dec;
            r_dp  <= ~bus.dp_en[r_idx];
            r_an  <= ~(4'b0001 << r_idx);
        end
    end

    assign bus.seg = r_seg;
    assign bus.dp  = r_dp;
    assign bus.an  = r_an;
endmodule
